// File: rtl/arb_pkg.sv
// Shared definitions for the arbiter bus stage: requester count, FSM state
// encoding and a one-hot to index helper.
package arb_pkg;

    localparam int NREQ = 4;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        XFER     = 2'd1,
        DONE     = 2'd2,
        WAIT_REL = 2'd3
    } state_t;

    // Lowest set bit wins, so a multi-bit vector still yields a usable index.
    function automatic logic [1:0] onehot_to_idx(input logic [NREQ-1:0] v);
        logic [1:0] r;
        r = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (v[i]) r = 2'(i);
        end
        return r;
    endfunction

endpackage

// File: rtl/arb_gnt_enc.sv
// Grant encoder: turns the arbiter's grant vector into an owner index plus
// "any grant" and "more than one grant" flags. Purely combinational.
module arb_gnt_enc
    import arb_pkg::*;
(
    input  logic [NREQ-1:0] gnt,
    output logic [1:0]      idx,
    output logic            any,
    output logic            multi
);

    assign idx   = onehot_to_idx(gnt);
    assign any   = |gnt;
    // Clearing the lowest set bit leaves something only if 2+ bits were set.
    assign multi = |(gnt & (gnt - NREQ'(1)));

endmodule

// File: rtl/arb_bus_ctrl.sv
// Bus controller downstream of the 4-requester arbiter. Latches the granted
// owner, forwards its beats onto a registered shared bus, counts a fixed
// burst and pulses Done back to the owner, then waits for the grant to drop.
// Optional build macro: ARB_BUS_GNT_CHECK_EN enables grant-error detection
// (non-one-hot grant in IDLE, foreign grant bits during XFER) on a sticky Err.
module arb_bus_ctrl
    import arb_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int BURST_LEN = 4
) (
    input  logic                   Clk,
    input  logic                   Reset,
    input  logic [NREQ-1:0]        Gnt,
    input  logic [NREQ*DATA_W-1:0] Data,
    input  logic [NREQ-1:0]        Valid,
    output logic [DATA_W-1:0]      BusData,
    output logic                   BusValid,
    output logic [1:0]             BusOwner,
    output logic                   Busy,
    output logic [NREQ-1:0]        Done,
    output logic                   Err
);

    localparam int CNT_W = $clog2(BURST_LEN + 1);

    state_t                  state;
    logic [CNT_W-1:0]        cnt;
    logic [CNT_W-1:0]        cnt_inc;
    logic                    last_beat;
    logic [1:0]              gnt_idx;
    logic                    gnt_any;
    logic                    gnt_multi;
    logic                    gnt_ok;
    logic [NREQ-1:0]         own_mask;
    logic                    own_gnt;
    logic                    own_vld;
    logic [DATA_W-1:0]       own_data;

    arb_gnt_enc u_gnt_enc (
        .gnt   (Gnt),
        .idx   (gnt_idx),
        .any   (gnt_any),
        .multi (gnt_multi)
    );

    assign own_mask  = NREQ'(1) << BusOwner;
    assign own_gnt   = Gnt[BusOwner];
    assign own_vld   = Valid[BusOwner];
    assign own_data  = Data[BusOwner*DATA_W +: DATA_W];
    assign cnt_inc   = cnt + 1'b1;
    assign last_beat = (cnt_inc == CNT_W'(BURST_LEN));

`ifdef ARB_BUS_GNT_CHECK_EN
    // Only a clean one-hot grant may start a burst.
    assign gnt_ok = gnt_any && !gnt_multi;

    // Sticky grant-error flag: ambiguous grant while idle, or a foreign grant mid-burst.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            Err <= 1'b0;
        end else if ((state == IDLE && gnt_multi) ||
                     (state == XFER && |(Gnt & ~own_mask))) begin
            Err <= 1'b1;
        end
    end
`else
    // Multi-bit grants resolve to the lowest index via the encoder.
    assign gnt_ok = gnt_any;
    assign Err    = 1'b0;

    logic unused_gnt_multi;
    assign unused_gnt_multi = gnt_multi;
`endif

    // Burst FSM with beat counter and registered bus/handshake outputs.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state    <= IDLE;
            cnt      <= '0;
            BusData  <= '0;
            BusValid <= 1'b0;
            BusOwner <= '0;
            Busy     <= 1'b0;
            Done     <= '0;
        end else begin
            BusValid <= 1'b0;
            Done     <= '0;
            case (state)
                IDLE: begin
                    if (gnt_ok) begin
                        BusOwner <= gnt_idx;
                        cnt      <= '0;
                        Busy     <= 1'b1;
                        state    <= XFER;
                    end
                end
                XFER: begin
                    if (!own_gnt) begin
                        // Grant withdrawn: abandon the burst, drop any beat this cycle.
                        cnt   <= '0;
                        Busy  <= 1'b0;
                        state <= IDLE;
                    end else if (own_vld) begin
                        BusData  <= own_data;
                        BusValid <= 1'b1;
                        cnt      <= cnt_inc;
                        if (last_beat) begin
                            Done  <= own_mask;
                            state <= DONE;
                        end
                    end
                end
                DONE: begin
                    state <= WAIT_REL;
                end
                WAIT_REL: begin
                    // Hold off until the arbiter releases this owner's grant.
                    if (!own_gnt) begin
                        Busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_arb_bus_ctrl.sv
// Scoreboard bench for arb_bus_ctrl: the driver queues expected bus beats and
// Done pulses, a negedge monitor pops and compares them as the DUT presents them.
module tb_arb_bus_ctrl;

    localparam int DW = 8;

    logic          Clk = 1'b0;
    logic          Reset;
    logic [3:0]    Gnt;
    logic [4*DW-1:0] Data;
    logic [3:0]    Valid;
    logic [DW-1:0] BusData;
    logic          BusValid;
    logic [1:0]    BusOwner;
    logic          Busy;
    logic [3:0]    Done;
    logic          Err;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [1:0]    owner;
        logic [DW-1:0] data;
    } beat_t;

    beat_t      beat_q[$];
    logic [3:0] done_q[$];
    beat_t      mon_beat;
    logic [3:0] mon_done;

    arb_bus_ctrl #(.DATA_W(DW), .BURST_LEN(4)) dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .Gnt      (Gnt),
        .Data     (Data),
        .Valid    (Valid),
        .BusData  (BusData),
        .BusValid (BusValid),
        .BusOwner (BusOwner),
        .Busy     (Busy),
        .Done     (Done),
        .Err      (Err)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    // Monitor: every presented beat / Done pulse must match the head of its queue.
    always @(negedge Clk) begin
        if (Reset === 1'b0) begin
            if (BusValid !== 1'b0) begin
                if (beat_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL beat_extra: got owner %0d data %0h, required no beat", BusOwner, BusData);
                end else begin
                    mon_beat = beat_q.pop_front();
                    check("beat_data", 32'(BusData), 32'(mon_beat.data));
                    check("beat_owner", 32'(BusOwner), 32'(mon_beat.owner));
                end
            end
            if (Done !== 4'b0000) begin
                if (done_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL done_extra: got %b, required 0000", Done);
                end else begin
                    mon_done = done_q.pop_front();
                    check("done_pulse", 32'(Done), 32'(mon_done));
                end
            end
        end
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // One cycle of stimulus; non-owners always show junk valid data to be ignored.
    task automatic drive(input int o, input bit v, input logic [7:0] d, input bit push, input bit last);
        Data  = {4{8'hEE}};
        Data[o*DW +: DW] = d;
        Valid = ~(4'b0001 << o);
        Valid[o] = v;
        if (push) beat_q.push_back({2'(o), d});
        if (last) done_q.push_back(4'b0001 << o);
        tick();
    endtask

    task automatic quiet();
        Valid = 4'b0000;
        Data  = '0;
    endtask

    // Full burst from XFER: 4 beats base..base+3, then the DONE cycle.
    task automatic burst(input int o, input logic [7:0] base);
        for (int b = 0; b < 4; b++) begin
            drive(o, 1'b1, base + 8'(b), 1'b1, b == 3);
        end
        quiet();
        tick();
    endtask

    initial begin
        // 1. Reset with random inputs, then idle with no grant.
        Reset = 1'b1;
        Gnt   = 4'b0000;
        quiet();
        for (int i = 0; i < 3; i++) begin
            Gnt   = 4'($urandom_range(0, 15));
            Valid = 4'($urandom_range(0, 15));
            Data  = 32'($urandom);
            tick();
            check("reset_outputs", {BusData, BusValid, BusOwner, Busy, Done, Err}, 32'd0);
        end
        Gnt = 4'b0000;
        quiet();
        Reset = 1'b0;
        tick();
        tick();
        check("idle_busy", 32'(Busy), 32'd0);
        check("idle_busvalid", 32'(BusValid), 32'd0);

        // 2. Owner 2, continuous valid, beats A0..A3.
        Gnt = 4'b0100;
        tick();
        check("t2_busy_xfer", 32'(Busy), 32'd1);
        check("t2_owner", 32'(BusOwner), 32'd2);
        burst(2, 8'hA0);
        check("t2_busy_wait", 32'(Busy), 32'd1);
        tick();
        check("t2_busy_hold", 32'(Busy), 32'd1);
        Gnt = 4'b0000;
        tick();
        check("t2_busy_release", 32'(Busy), 32'd0);

        // 3. Owner 0, gappy valid 1,0,1,0,1,1.
        Gnt = 4'b0001;
        tick();
        begin
            bit pat[6] = '{1, 0, 1, 0, 1, 1};
            int n = 0;
            for (int i = 0; i < 6; i++) begin
                if (pat[i]) n++;
                drive(0, pat[i], 8'h10 + 8'(i), pat[i], pat[i] && n == 4);
                check("t3_align", 32'(BusValid), 32'(pat[i]));
            end
        end
        quiet();
        tick();
        Gnt = 4'b0000;
        tick();
        check("t3_release", 32'(Busy), 32'd0);

        // 4. Owner 3 aborted after 2 beats, then a fresh burst for owner 1.
        Gnt = 4'b1000;
        tick();
        drive(3, 1'b1, 8'hC0, 1'b1, 1'b0);
        drive(3, 1'b1, 8'hC1, 1'b1, 1'b0);
        Gnt = 4'b0000;
        drive(3, 1'b1, 8'hC2, 1'b0, 1'b0);
        check("t4_abort_busy", 32'(Busy), 32'd0);
        check("t4_abort_done", 32'(Done), 32'd0);
        check("t4_abort_beat", 32'(BusValid), 32'd0);
        quiet();
        Gnt = 4'b0010;
        tick();
        check("t4_owner", 32'(BusOwner), 32'd1);
        burst(1, 8'hB0);
        Gnt = 4'b0000;
        tick();

        // 5. Grant held after Done: no second burst; then owner 1.
        Gnt = 4'b0001;
        tick();
        burst(0, 8'hD0);
        drive(0, 1'b1, 8'h55, 1'b0, 1'b0);
        drive(0, 1'b1, 8'h56, 1'b0, 1'b0);
        check("t5_hold_busy", 32'(Busy), 32'd1);
        check("t5_hold_beat", 32'(BusValid), 32'd0);
        quiet();
        Gnt = 4'b0010;
        tick();
        check("t5_to_idle", 32'(Busy), 32'd0);
        tick();
        check("t5_owner", 32'(BusOwner), 32'd1);
        burst(1, 8'hE0);
        Gnt = 4'b0000;
        tick();

        // 6. Multi-bit grant in IDLE.
        Gnt = 4'b0110;
        tick();
`ifdef ARB_BUS_GNT_CHECK_EN
        check("t6_err", 32'(Err), 32'd1);
        check("t6_no_burst", 32'(Busy), 32'd0);
        tick();
        check("t6_still_idle", 32'(Busy), 32'd0);
        Gnt = 4'b0000;
        tick();
        check("t6_err_sticky", 32'(Err), 32'd1);
`else
        check("t6_err", 32'(Err), 32'd0);
        check("t6_busy", 32'(Busy), 32'd1);
        check("t6_owner", 32'(BusOwner), 32'd1);
        burst(1, 8'h60);
        Gnt = 4'b0000;
        tick();
`endif

        // 7. Reset mid-burst after two beats.
        Gnt = 4'b0100;
        tick();
        drive(2, 1'b1, 8'h70, 1'b1, 1'b0);
        drive(2, 1'b1, 8'h71, 1'b1, 1'b0);
        quiet();
        @(negedge Clk);
        #1;
        Reset = 1'b1;
        #1;
        check("t7_async_reset", {BusData, BusValid, BusOwner, Busy, Done, Err}, 32'd0);
        Gnt = 4'b0000;
        tick();
        tick();
        Reset = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        check("t7_after_busy", 32'(Busy), 32'd0);
        check("t7_after_done", 32'(Done), 32'd0);

        check("beats_pending", 32'(beat_q.size()), 32'd0);
        check("dones_pending", 32'(done_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
